// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: ALU operation codes,
// instruction opcode/funct values, controller state encoding and mux selects.
package mips_pkg;

  // ALU operation codes understood by the datapath ALU
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_NOR  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_ADDI = 4'd6;
  localparam logic [3:0] ALU_ORI  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_ANDI = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'b1010;  // A - B, used for branch compare

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct values (IR[5:0])
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;

  // Controller states; FETCH is zero so the reset state reads as all-zero
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // ALU B operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational instruction classifier: maps Opcode/Funct to the ALU
// operation, immediate extension mode and whether the encoding is supported.
module alu_op_decoder
  import mips_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic [3:0] ALUOperation,
  output logic       ExtZero,
  output logic       legal
);

  // Decode table; memory/branch/jump opcodes are legal but use ADD here
  always_comb begin
    ALUOperation = ALU_ADD;
    ExtZero      = 1'b0;
    legal        = 1'b1;
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          F_ADD:   ALUOperation = ALU_ADD;
          F_AND:   ALUOperation = ALU_AND;
          F_OR:    ALUOperation = ALU_OR;
          F_NOR:   ALUOperation = ALU_NOR;
          F_SLL:   ALUOperation = ALU_SLL;
          F_SRL:   ALUOperation = ALU_SRL;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: ALUOperation = ALU_ADDI;
      OP_ANDI: begin
        ALUOperation = ALU_ANDI;
        ExtZero      = 1'b1;
      end
      OP_ORI: begin
        ALUOperation = ALU_ORI;
        ExtZero      = 1'b1;
      end
      OP_LUI: ALUOperation = ALU_LUI;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with Moore datapath controls, memory-ready
// stalls, illegal-instruction pulse and a retired-instruction counter.
// Handshake: MemReady=1 in FETCH/MEM_RD/MEM_WR means the memory access
// presented this cycle completes at the next rising clk; otherwise the
// state and its strobes hold unchanged.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [3:0]  ALUOperation,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        ExtZero,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        PCEn,
  output logic [1:0]  PCSource,
  output logic        IllegalInstr,
  output logic [31:0] RetiredCount,
  output logic [3:0]  o_dbg_state
);

  state_e      r_state;
  state_e      w_next_state;
  logic [31:0] r_retired_count;
  logic [3:0]  w_dec_op;
  logic        w_dec_extzero;
  logic        w_legal;
  logic        w_retire;

  alu_op_decoder u_dec (
    .Opcode       (Opcode),
    .Funct        (Funct),
    .ALUOperation (w_dec_op),
    .ExtZero      (w_dec_extzero),
    .legal        (w_legal)
  );

  // Next-state selection
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!w_legal) begin
          w_next_state = S_FETCH;
        end else begin
          case (Opcode)
            OP_RTYPE:                         w_next_state = S_EXEC_R;
            OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next_state = S_EXEC_I;
            OP_BEQ, OP_BNE:                   w_next_state = S_BRANCH;
            OP_J:                             w_next_state = S_JUMP;
            default:                          w_next_state = S_FETCH;
          endcase
        end
      end
      S_EXEC_R:   w_next_state = S_R_WB;
      S_EXEC_I:   w_next_state = S_I_WB;
      S_MEM_ADDR: w_next_state = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = MemReady ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   w_next_state = MemReady ? S_FETCH : S_MEM_WR;
      default:    w_next_state = S_FETCH;  // write-backs, branch, jump, unused codes
    endcase
  end

  // An instruction retires on the edge that returns from its last state
  always_comb begin
    case (r_state)
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WR:                                   w_retire = MemReady;
      default:                                    w_retire = 1'b0;
    endcase
  end

  // State and retired-instruction counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_FETCH;
      r_retired_count <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_retired_count <= r_retired_count + 32'd1;
    end
  end

  // Control outputs; forced low while reset is held so strobes drop at once
  always_comb begin
    ALUOperation = 4'd0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_B;
    ExtZero      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    PCEn         = 1'b0;
    PCSource     = PC_ALU;
    IllegalInstr = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead      = 1'b1;
          ALUSrcB      = SRCB_FOUR;
          ALUOperation = ALU_ADD;
          IRWrite      = MemReady;
          PCEn         = MemReady;
        end
        S_DECODE: begin
          ALUSrcB      = SRCB_IMM_SH2;
          ALUOperation = ALU_ADD;
          IllegalInstr = ~w_legal;
        end
        S_EXEC_R: begin
          ALUSrcA      = 1'b1;
          ALUOperation = w_dec_op;
        end
        S_R_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_EXEC_I: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_IMM;
          ALUOperation = w_dec_op;
          ExtZero      = w_dec_extzero;
        end
        S_I_WB: RegWrite = 1'b1;
        S_MEM_ADDR: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = SRCB_IMM;
          ALUOperation = ALU_ADD;
        end
        S_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUOperation = ALU_SUB;
          PCSource     = PC_ALUOUT;
          PCEn         = (Opcode == OP_BNE) ? ~Zero : Zero;
        end
        S_JUMP: begin
          PCSource = PC_JUMP;
          PCEn     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign RetiredCount = r_retired_count;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction cycle plans are built
// from the instruction rules and pushed to an expected queue; a monitor pops
// one expected control word + retired count per cycle and compares.
module tb_mips_multicycle_control;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  Opcode = 6'd0;
  logic [5:0]  Funct = 6'd0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic [3:0]  ALUOperation;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        ExtZero, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, PCEn;
  logic [1:0]  PCSource;
  logic        IllegalInstr;
  logic [31:0] RetiredCount;
  logic [3:0]  o_dbg_state;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .PCEn(PCEn), .PCSource(PCSource),
    .IllegalInstr(IllegalInstr), .RetiredCount(RetiredCount), .o_dbg_state(o_dbg_state)
  );

  logic [18:0] act_cw;
  assign act_cw = {ALUOperation, ALUSrcA, ALUSrcB, ExtZero, IorD, MemRead, MemWrite,
                   IRWrite, RegDst, MemtoReg, RegWrite, PCEn, PCSource, IllegalInstr};

  // ---------------- scoreboard ----------------
  int          n_total = 0;
  int          n_bad = 0;
  logic [50:0] exp_q[$];
  logic [31:0] exp_count = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [18:0] mk(input logic [3:0] aop, input logic sa, input logic [1:0] sb,
                                     input logic ez, input logic iod, input logic mr, input logic mw,
                                     input logic irw, input logic rd, input logic m2r, input logic rw,
                                     input logic pce, input logic [1:0] pcs, input logic ill);
    return {aop, sa, sb, ez, iod, mr, mw, irw, rd, m2r, rw, pce, pcs, ill};
  endfunction

  function automatic int r_op(input logic [5:0] f);
    case (f)
      6'h20: return 3;
      6'h24: return 0;
      6'h25: return 1;
      6'h27: return 2;
      6'h00: return 4;
      6'h02: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int i_op(input logic [5:0] op);
    case (op)
      6'h08: return 6;
      6'h0C: return 9;
      6'h0D: return 7;
      6'h0F: return 8;
      default: return -1;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return r_op(fn) >= 0;
    return (i_op(op) >= 0) || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h05 || op == 6'h02;
  endfunction

  function automatic logic [18:0] fetch_cw(input logic rdy);
    return mk(4'd3, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, rdy, 1'b0, 1'b0, 1'b0, rdy, 2'b00, 1'b0);
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rel, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic z, input logic [18:0] cw);
    @(posedge clk);
    #1;
    if (rel) reset = 1'b0;
    Opcode = op;
    Funct = fn;
    MemReady = mr;
    Zero = z;
    exp_q.push_back({cw, exp_count});
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fst,
                          input int mst, input logic z);
    bit ill;
    ill = !is_legal(op, fn);
    for (int i = 0; i < fst; i++) step(1'b0, op, fn, 1'b0, z, fetch_cw(1'b0));
    step(1'b0, op, fn, 1'b1, z, fetch_cw(1'b1));
    step(1'b0, op, fn, rb(), z, mk(4'd3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, logic'(ill)));
    if (ill) return;
    if (op == 6'h00) begin
      step(1'b0, op, fn, rb(), z, mk(4'(r_op(fn)), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      step(1'b0, op, fn, rb(), z, mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
    end else if (i_op(op) >= 0) begin
      step(1'b0, op, fn, rb(), z, mk(4'(i_op(op)), 1'b1, 2'b10, logic'(op == 6'h0C || op == 6'h0D),
                                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      step(1'b0, op, fn, rb(), z, mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0));
    end else if (op == 6'h23 || op == 6'h2B) begin
      step(1'b0, op, fn, rb(), z, mk(4'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      for (int i = 0; i <= mst; i++)
        step(1'b0, op, fn, logic'(i == mst), z,
             mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b1, logic'(op == 6'h23), logic'(op == 6'h2B),
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
      if (op == 6'h23)
        step(1'b0, op, fn, rb(), z, mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
    end else if (op == 6'h04 || op == 6'h05) begin
      step(1'b0, op, fn, rb(), z, mk(4'b1010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, (op == 6'h04) ? z : ~z, 2'b01, 1'b0));
    end else begin
      step(1'b0, op, fn, rb(), z, mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0));
    end
    exp_count = exp_count + 32'd1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [50:0] e;
    forever begin
      @(negedge clk);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl_word", 32'(act_cw), 32'(e[50:32]));
        chk("retired", RetiredCount, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] op, fn;
    logic [5:0] legal_f[6] = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
    logic [5:0] i_ops[4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
    int sel;

    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'(act_cw), 32'd0);
    chk("rst_cnt", RetiredCount, 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'(S_FETCH));

    step(1'b1, 6'h00, 6'h20, 1'b0, 1'b0, fetch_cw(1'b0));

    // directed cases
    do_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add
    do_instr(6'h23, 6'h11, 0, 2, 1'b0);   // lw, two-cycle memory stall
    do_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
    do_instr(6'h05, 6'h00, 0, 0, 1'b1);   // bne not taken
    do_instr(6'h3F, 6'h00, 0, 0, 1'b0);   // illegal opcode
    do_instr(6'h00, 6'h08, 0, 0, 1'b0);   // illegal funct
    do_instr(6'h2B, 6'h00, 1, 1, 1'b0);   // sw with stalls
    do_instr(6'h0C, 6'h00, 0, 0, 1'b0);   // andi
    do_instr(6'h0F, 6'h00, 0, 0, 1'b0);   // lui
    do_instr(6'h02, 6'h00, 0, 0, 1'b0);   // j

    // random mix
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      fn = 6'($urandom_range(0, 63));
      case (sel)
        0, 9: begin op = 6'h00; fn = legal_f[$urandom_range(0, 5)]; end
        1: begin
          op = 6'h00;
          do fn = 6'($urandom_range(0, 63)); while (r_op(fn) >= 0);
        end
        2: op = i_ops[$urandom_range(0, 3)];
        3: op = 6'h23;
        4: op = 6'h2B;
        5: op = 6'h04;
        6: op = 6'h05;
        7: op = 6'h02;
        default: begin
          do op = 6'($urandom_range(0, 63)); while (op == 6'h00 || is_legal(op, 6'h00));
        end
      endcase
      do_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), rb());
    end

    // reset in the middle of a stalled store
    step(1'b0, 6'h2B, 6'h00, 1'b1, 1'b0, fetch_cw(1'b1));
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(4'd3, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(4'd3, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    step(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, mk(4'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
    @(negedge clk);
    #1;
    chk("pre_rst_mw", 32'(MemWrite), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mw_drop", 32'(MemWrite), 32'd0);
    chk("rst_mid_ctl", 32'(act_cw), 32'd0);
    chk("rst_mid_cnt", RetiredCount, 32'd0);
    exp_count = 32'd0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_ctl", 32'(act_cw), 32'd0);
      chk("rst_hold_state", 32'(o_dbg_state), 32'(S_FETCH));
    end
    step(1'b1, 6'h02, 6'h00, 1'b0, 1'b0, fetch_cw(1'b0));

    // preload the counter to all-ones, then retire a jump to wrap it
    @(posedge clk);
    #1;
    force dut.r_retired_count = 32'hFFFF_FFFF;
    exp_count = 32'hFFFF_FFFF;
    MemReady = 1'b0;
    exp_q.push_back({fetch_cw(1'b0), exp_count});
    @(posedge clk);
    #1;
    release dut.r_retired_count;
    exp_q.push_back({fetch_cw(1'b0), exp_count});
    do_instr(6'h02, 6'h00, 0, 0, 1'b0);
    do_instr(6'h00, 6'h25, 0, 0, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, fetch_cw(1'b0));

    repeat (2) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  reset; asynchronous, active-high.
REQ-003 Opcode  input  6  IR[31:26].
REQ-004 Funct  input  6  IR[5:0].
REQ-005 Zero  input  1  ALU zero flag, combinational in the current cycle.
REQ-006 MemReady  input  1  memory completes the current read/write this cycle.
REQ-007 ALUOperation  output  4  ALU op code.
REQ-008 ALUSrcA  output  1  ALU A operand: 0=PC, 1=A reg.
REQ-009 ALUSrcB  output  2  ALU B operand: 00=B reg, 01=constant 4, 10=extended imm, 11=sign-extended imm<<2.
REQ-010 ExtZero  output  1  imm extension: 1=zero-extend, 0=sign-extend.
REQ-011 IorD  output  1  memory address: 0=PC, 1=ALUOut.
REQ-012 MemRead  output  1  memory read strobe.
REQ-013 MemWrite  output  1  memory write strobe.
REQ-014 IRWrite  output  1  instruction register load.
REQ-015 RegDst  output  1  write register: 0=rt, 1=rd.
REQ-016 MemtoReg  output  1  write data: 0=ALUOut, 1=MDR.
REQ-017 RegWrite  output  1  register file write enable.
REQ-018 PCEn  output  1  PC load enable.
REQ-019 PCSource  output  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target.
REQ-020 IllegalInstr  output  1  one-cycle pulse on an unsupported encoding.
REQ-021 RetiredCount  output  32  completed-instruction counter.

Function
REQ-022 States: FETCH, DECODE, EXEC_R, R_WB, EXEC_I, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP; unused encodings -> FETCH.
REQ-023 Outputs are Moore and 0 unless listed for the state; PCEn, IRWrite and IllegalInstr additionally depend on the inputs named below.
REQ-024 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=ADD, PCSource=00; IRWrite=PCEn=MemReady; stay while MemReady=0, else -> DECODE.
REQ-025 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOperation=ADD; next state by Opcode: 0x00 -> EXEC_R; 0x23/0x2B -> MEM_ADDR; 0x08/0x0C/0x0D/0x0F -> EXEC_I; 0x04/0x05 -> BRANCH; 0x02 -> JUMP.
REQ-026 Legal R-type Funct values: 0x20 ADD, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL.
REQ-027 Any other Opcode, or Opcode 0x00 with any other Funct, pulses IllegalInstr in DECODE -> FETCH; no register, memory or PC write.
REQ-028 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOperation mapped from Funct -> R_WB.
REQ-029 R_WB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-030 EXEC_I: ALUSrcA=1, ALUSrcB=10; ALUOperation ADDI/ANDI/ORI/LUI; ExtZero=1 for 0x0C and 0x0D only -> I_WB.
REQ-031 I_WB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
REQ-032 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOperation=ADD -> MEM_RD if Opcode=0x23, else -> MEM_WR.
REQ-033 MEM_RD: MemRead=1, IorD=1; hold until MemReady=1 -> MEM_WB.
REQ-034 MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
REQ-035 MEM_WR: MemWrite=1, IorD=1; hold until MemReady=1 -> FETCH.
REQ-036 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOperation=SUB, PCSource=01; PCEn=Zero for beq, ~Zero for bne -> FETCH.
REQ-037 JUMP: PCSource=10, PCEn=1 -> FETCH.
REQ-038 Latency with MemReady=1: R/I-type 4, sw 4, lw 5, beq/bne/j 3 cycles; each MemReady=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
REQ-039 Opcode/Funct are stable from DECODE until the next FETCH IRWrite; the block stores no copy of them.
REQ-040 RetiredCount increments by 1 on each exit to FETCH from R_WB, I_WB, MEM_WB, MEM_WR, BRANCH or JUMP; illegal instructions do not count; wraps 0xFFFFFFFF -> 0.

Reset
REQ-041 While reset=1: state=FETCH, RetiredCount=0, all outputs 0 (FETCH Moore outputs suppressed); strobes drop immediately on assertion, including mid-MEM_RD/MEM_WR.
REQ-042 The first rising clk edge after deassertion is in FETCH with MemRead=1.

Structure
REQ-043 Shared package mips_pkg holds: ALU op codes (AND=0, OR=1, NOR=2, ADD=3, SLL=4, SRL=5, ADDI=6, ORI=7, LUI=8, ANDI=9, new SUB=4'b1010, which the ALU decoder computes as A-B); opcode and Funct constants; the state enum; ALUSrcB and PCSource encodings.
REQ-044 One sub-module, alu_op_decoder (combinational): Opcode/Funct -> ALUOperation, ExtZero, legal.

Verification
REQ-045 add (Op 0x00, Funct 0x20), MemReady=1 -> states FETCH, DECODE, EXEC_R, R_WB; ALUOperation=3 in EXEC_R; RegWrite=1 with RegDst=1 in R_WB only; RetiredCount 0 -> 1.
REQ-046 lw (0x23), MemReady held 0 for 2 cycles in MEM_RD -> 7 cycles total; MemRead=1, IorD=1 throughout the stall; MemtoReg=1 and RegWrite=1 in MEM_WB.
REQ-047 beq with Zero=1 -> PCEn=1, PCSource=01, ALUOperation=4'b1010; bne with Zero=1 -> PCEn=0.
REQ-048 Opcode 0x3F, then Op 0x00 with Funct 0x08 -> IllegalInstr=1 for one cycle in DECODE, no writes, return to FETCH, RetiredCount unchanged.
REQ-049 reset asserted mid-MEM_WR -> MemWrite falls without a clk edge; after release the state is FETCH and RetiredCount=0; preload 0xFFFFFFFF and retire j -> RetiredCount=0.
